fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, packet-FIFO entries; power of two, at least 2.
REQ-002 SHALL have port cpu_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have port flush_i  in  1  pipeline flush; discards all buffered packets.
REQ-005 SHALL have port hit_i  in  1  icache packet valid.
REQ-006 SHALL have port instruction_i  in  64  fetch packet: [31:0] lane0 word, [63:32] lane1 word.
REQ-007 SHALL have port vpc_i  in  32  virtual PC of the fetch.
REQ-008 SHALL have port excp_code_i  in  4  fetch exception code.
REQ-009 SHALL have port excp_vld_i  in  1  fetch exception valid.
REQ-010 SHALL have btb_index_i (1), btb_btype_i (2), btb_bm_pred_i (2), btb_target_i (32), btb_vld_i (1), btb_way_i (1), all inputs, carrying the BTB prediction.
REQ-011 SHALL have port busy_o  out  1  backpressure to the icache.
REQ-012 SHALL have port pkt_vld_o  out  1  head packet valid to decode.
REQ-013 SHALL have ports ins0_o, ins1_o  out  32 each  lane instruction words.
REQ-014 SHALL have ports lane0_vld_o, lane1_vld_o  out  1 each  lane valid.
REQ-015 SHALL have port pc_o  out  32  head packet PC, {vpc[31:3],3'b000}.
REQ-016 SHALL have excp_code_o (4) and excp_vld_o (1), plus btb_index_o, btb_btype_o, btb_bm_pred_o, btb_target_o, btb_vld_o, btb_way_o, all outputs with the widths given in REQ-010.
REQ-017 SHALL have port busy_i  in  1  decode stall.

Function
REQ-018 SHALL enqueue when hit_i && !busy_o && !flush_i; the icache holds its outputs while busy_o is high.
REQ-019 SHALL drive busy_o = (count == DEPTH), combinationally from registered count; a dequeue in the same cycle does not lower it.
REQ-020 SHALL dequeue when pkt_vld_o && !busy_i && !flush_i; pkt_vld_o = (count != 0).
REQ-021 SHALL show the head entry combinationally on all output ports, with no extra latency; an enqueue into an empty FIFO is visible on the next cycle.
REQ-022 SHALL compute lane validity at enqueue: lane0 = !vpc_i[2].
REQ-023 SHALL define taken = btb_vld_i && (btb_btype_i != 2'b00 || btb_bm_pred_i[1]).
REQ-024 SHALL compute lane1 = !(lane0 && taken && btb_index_i == 0).
REQ-025 SHALL, when excp_vld_i is set, keep only the first valid lane and zero both instruction words in the stored entry.
REQ-026 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and move both pointers; this is legal when full (no enqueue then per REQ-019) and when empty (no dequeue).
REQ-027 SHALL wrap read and write pointers modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-028 SHALL give flush_i priority over enqueue and dequeue: next cycle count = 0, pointers = 0, pkt_vld_o = 0, busy_o = 0.
REQ-029 SHALL never drive an entry not written since the last reset or flush with pkt_vld_o high.

Reset
REQ-030 SHALL, on cpu_rst_i, clear count and both pointers, forcing pkt_vld_o = 0 and busy_o = 0 next cycle.
REQ-031 SHALL give cpu_rst_i priority over flush_i, enqueue and dequeue; entry storage is not reset.
REQ-032 SHALL drive all data outputs 0 while pkt_vld_o = 0.

Structure
REQ-033 SHALL place the packet struct (instructions, pc[31:3], lane valids, exception, BTB fields) and the branch-type encodings in a shared frontend package.
REQ-034 SHALL implement lane qualification as sub-module fetch_lane_qual (combinational), feeding a single FIFO storage array.

Verification
REQ-035 SHALL cover: vpc 0x1000, no BTB, busy_i = 0 -> next cycle pkt_vld_o = 1, both lanes valid, pc_o = 0x1000.
REQ-036 SHALL cover: vpc 0x1004 -> lane0_vld_o = 0, lane1_vld_o = 1, pc_o = 0x1000.
REQ-037 SHALL cover: vpc 0x2000, btb_vld = 1, btype = 00, bm_pred = 2'b10, index 0 -> lane1_vld_o = 0; with bm_pred = 2'b01 -> lane1_vld_o = 1.
REQ-038 SHALL cover: DEPTH = 4, busy_i = 1, five consecutive hits -> busy_o high after the fourth; the fifth is held and then accepted after one dequeue; order preserved.
REQ-039 SHALL cover: three entries buffered, flush_i for one cycle with hit_i = 1 -> next cycle pkt_vld_o = 0, count = 0, flush-cycle packet dropped.
REQ-040 SHALL cover: excp_vld_i = 1, code 4'hC, vpc 0x3004 -> lane0 = 0, lane1 = 1, ins1_o = 0, excp_code_o = 4'hC.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: fetch packet layout and BTB branch-type encodings shared by the frontend.
package fetch_buffer_pkg;
   typedef enum logic [1:0] {
      BT_NONE = 2'b00,
      BT_JMP  = 2'b01,
      BT_CALL = 2'b10,
      BT_RET  = 2'b11
   } btb_btype_e;
   typedef struct packed {
      logic [31:0] ins0;
      logic [31:0] ins1;
      logic [28:0] pc;
      logic        lane0_vld;
      logic        lane1_vld;
      logic [3:0]  excp_code;
      logic        excp_vld;
      logic        btb_index;
      logic [1:0]  btb_btype;
      logic [1:0]  btb_bm_pred;
      logic [31:0] btb_target;
      logic        btb_vld;
      logic        btb_way;
   } fetch_pkt_t;
endpackage

// File: rtl/fetch_lane_qual.sv
// fetch_lane_qual: decides which lanes of a fetch packet are live and scrubs faulting words.
module fetch_lane_qual
   import fetch_buffer_pkg::*;
(
   input  logic        vpc_bit2_i,
   input  logic [63:0] instruction_i,
   input  logic        excp_vld_i,
   input  logic        btb_vld_i,
   input  logic [1:0]  btb_btype_i,
   input  logic        btb_bm_taken_i,
   input  logic        btb_index_i,
   output logic        lane0_vld_o,
   output logic        lane1_vld_o,
   output logic [31:0] ins0_o,
   output logic [31:0] ins1_o
);
   logic taken;
   logic lane1_raw;
   always_comb begin
      taken       = btb_vld_i && (btb_btype_i != BT_NONE || btb_bm_taken_i);
      lane0_vld_o = !vpc_bit2_i;
      lane1_raw   = !(lane0_vld_o && taken && !btb_index_i);
      // an exception keeps only the first live lane
      lane1_vld_o = lane1_raw && !(excp_vld_i && lane0_vld_o);
      ins0_o      = excp_vld_i ? 32'h0 : instruction_i[31:0];
      ins1_o      = excp_vld_i ? 32'h0 : instruction_i[63:32];
   end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: packet FIFO between icache and decode with lane qualification at enqueue.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        cpu_clk_i,
   input  logic        cpu_rst_i,
   input  logic        flush_i,
   input  logic        hit_i,
   input  logic [63:0] instruction_i,
   input  logic [31:0] vpc_i,
   input  logic [3:0]  excp_code_i,
   input  logic        excp_vld_i,
   input  logic        btb_index_i,
   input  logic [1:0]  btb_btype_i,
   input  logic [1:0]  btb_bm_pred_i,
   input  logic [31:0] btb_target_i,
   input  logic        btb_vld_i,
   input  logic        btb_way_i,
   input  logic        busy_i,
   output logic        busy_o,
   output logic        pkt_vld_o,
   output logic [31:0] ins0_o,
   output logic [31:0] ins1_o,
   output logic        lane0_vld_o,
   output logic        lane1_vld_o,
   output logic [31:0] pc_o,
   output logic [3:0]  excp_code_o,
   output logic        excp_vld_o,
   output logic        btb_index_o,
   output logic [1:0]  btb_btype_o,
   output logic [1:0]  btb_bm_pred_o,
   output logic [31:0] btb_target_o,
   output logic        btb_vld_o,
   output logic        btb_way_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] full_cnt = CW'(DEPTH);
   fetch_pkt_t          mem_q [DEPTH];
   fetch_pkt_t          new_pkt, head;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                push, pop;
   logic                lane0, lane1;
   logic [31:0]         ins0, ins1;
   logic                unused_vpc;
   assign unused_vpc = ^vpc_i[1:0];
   fetch_lane_qual u_qual (
      .vpc_bit2_i     (vpc_i[2]),
      .instruction_i  (instruction_i),
      .excp_vld_i     (excp_vld_i),
      .btb_vld_i      (btb_vld_i),
      .btb_btype_i    (btb_btype_i),
      .btb_bm_taken_i (btb_bm_pred_i[1]),
      .btb_index_i    (btb_index_i),
      .lane0_vld_o    (lane0),
      .lane1_vld_o    (lane1),
      .ins0_o         (ins0),
      .ins1_o         (ins1)
   );
   always_comb begin
      new_pkt = '{ins0: ins0, ins1: ins1, pc: vpc_i[31:3], lane0_vld: lane0, lane1_vld: lane1,
                  excp_code: excp_code_i, excp_vld: excp_vld_i, btb_index: btb_index_i,
                  btb_btype: btb_btype_i, btb_bm_pred: btb_bm_pred_i, btb_target: btb_target_i,
                  btb_vld: btb_vld_i, btb_way: btb_way_i};
      busy_o    = count_q == full_cnt;
      pkt_vld_o = count_q != '0;
      push      = hit_i && !busy_o && !flush_i;
      pop       = pkt_vld_o && !busy_i && !flush_i;
      wr_ptr_d  = flush_i ? '0 : push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = flush_i ? '0 : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = flush_i ? '0 : (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
      // empty FIFO shows an all-zero packet so stale storage never leaks out
      head      = pkt_vld_o ? mem_q[rd_ptr_q] : '0;
   end
   always_ff @(posedge cpu_clk_i) begin
      if (cpu_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   always_ff @(posedge cpu_clk_i) begin
      if (push && !cpu_rst_i) mem_q[wr_ptr_q] <= new_pkt;
   end
   assign ins0_o        = head.ins0;
   assign ins1_o        = head.ins1;
   assign lane0_vld_o   = head.lane0_vld;
   assign lane1_vld_o   = head.lane1_vld;
   assign pc_o          = {head.pc, 3'b000};
   assign excp_code_o   = head.excp_code;
   assign excp_vld_o    = head.excp_vld;
   assign btb_index_o   = head.btb_index;
   assign btb_btype_o   = head.btb_btype;
   assign btb_bm_pred_o = head.btb_bm_pred;
   assign btb_target_o  = head.btb_target;
   assign btb_vld_o     = head.btb_vld;
   assign btb_way_o     = head.btb_way;
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of fetch_buffer with hand-computed expectations.
module tb_fetch_buffer;
   logic        clk = 0;
   logic        rst, flush, hit, busy_i;
   logic [63:0] instruction;
   logic [31:0] vpc, btb_target;
   logic [3:0]  excp_code;
   logic        excp_vld, btb_index, btb_vld, btb_way;
   logic [1:0]  btb_btype, btb_bm_pred;
   logic        busy_o, pkt_vld, lane0, lane1, excp_vld_o, btb_index_o, btb_vld_o, btb_way_o;
   logic [31:0] ins0, ins1, pc, btb_target_o;
   logic [3:0]  excp_code_o;
   logic [1:0]  btb_btype_o, btb_bm_pred_o;
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   fetch_buffer #(.DEPTH(4)) dut (
      .cpu_clk_i(clk), .cpu_rst_i(rst), .flush_i(flush), .hit_i(hit),
      .instruction_i(instruction), .vpc_i(vpc), .excp_code_i(excp_code), .excp_vld_i(excp_vld),
      .btb_index_i(btb_index), .btb_btype_i(btb_btype), .btb_bm_pred_i(btb_bm_pred),
      .btb_target_i(btb_target), .btb_vld_i(btb_vld), .btb_way_i(btb_way), .busy_i(busy_i),
      .busy_o(busy_o), .pkt_vld_o(pkt_vld), .ins0_o(ins0), .ins1_o(ins1),
      .lane0_vld_o(lane0), .lane1_vld_o(lane1), .pc_o(pc), .excp_code_o(excp_code_o),
      .excp_vld_o(excp_vld_o), .btb_index_o(btb_index_o), .btb_btype_o(btb_btype_o),
      .btb_bm_pred_o(btb_bm_pred_o), .btb_target_o(btb_target_o), .btb_vld_o(btb_vld_o),
      .btb_way_o(btb_way_o)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] v, input logic bv, input logic [1:0] bt,
                        input logic [1:0] bm, input logic idx, input logic ev, input logic [3:0] ec);
      hit = 1; vpc = v; instruction = {v + 32'h100, v + 32'h200};
      btb_vld = bv; btb_btype = bt; btb_bm_pred = bm; btb_index = idx;
      excp_vld = ev; excp_code = ec; btb_target = 32'hDEADBEE0; btb_way = 1;
   endtask
   initial begin
      rst = 1; flush = 0; hit = 0; busy_i = 0;
      drive(32'h0, 0, 2'b00, 2'b00, 0, 0, 4'h0);
      hit = 0;
      step(); step();
      rst = 0;
      chk("rst_pkt_vld", pkt_vld, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ins0_zero", ins0, 0);
      chk("rst_pc_zero", pc, 0);
      drive(32'h1000, 0, 2'b00, 2'b00, 0, 0, 4'h0);
      step();
      hit = 0;
      chk("basic_vld", pkt_vld, 1);
      chk("basic_lane0", lane0, 1);
      chk("basic_lane1", lane1, 1);
      chk("basic_pc", pc, 32'h1000);
      chk("basic_ins0", ins0, 32'h1200);
      chk("basic_ins1", ins1, 32'h1100);
      drive(32'h1004, 0, 2'b00, 2'b00, 0, 0, 4'h0);
      step();
      chk("odd_lane0", lane0, 0);
      chk("odd_lane1", lane1, 1);
      chk("odd_pc", pc, 32'h1000);
      drive(32'h2000, 1, 2'b00, 2'b10, 0, 0, 4'h0);
      step();
      chk("bm_taken_lane1", lane1, 0);
      chk("bm_taken_btbvld", btb_vld_o, 1);
      chk("bm_taken_pred", btb_bm_pred_o, 2'b10);
      chk("bm_taken_target", btb_target_o, 32'hDEADBEE0);
      drive(32'h2000, 1, 2'b00, 2'b01, 0, 0, 4'h0);
      step();
      chk("bm_nt_lane1", lane1, 1);
      drive(32'h2000, 1, 2'b10, 2'b00, 0, 0, 4'h0);
      step();
      chk("btype_lane1", lane1, 0);
      chk("btype_out", btb_btype_o, 2'b10);
      drive(32'h2000, 1, 2'b01, 2'b00, 1, 0, 4'h0);
      step();
      chk("idx1_lane1", lane1, 1);
      hit = 0;
      step();
      chk("drain_vld", pkt_vld, 0);
      chk("drain_target_zero", btb_target_o, 0);
      drive(32'h3004, 0, 2'b00, 2'b00, 0, 1, 4'hC);
      step();
      hit = 0;
      chk("exc_lane0", lane0, 0);
      chk("exc_lane1", lane1, 1);
      chk("exc_ins1", ins1, 0);
      chk("exc_code", excp_code_o, 4'hC);
      chk("exc_vld", excp_vld_o, 1);
      step();
      drive(32'h3000, 0, 2'b00, 2'b00, 0, 1, 4'h3);
      step();
      hit = 0;
      chk("exc_even_lane0", lane0, 1);
      chk("exc_even_lane1", lane1, 0);
      chk("exc_even_ins0", ins0, 0);
      step();
      chk("exc_drain_vld", pkt_vld, 0);
      busy_i = 1;
      for (int i = 0; i < 4; i++) begin
         drive(32'h4000 + 32'(i) * 8, 0, 2'b00, 2'b00, 0, 0, 4'h0);
         step();
      end
      chk("full_busy", busy_o, 1);
      chk("full_head_pc", pc, 32'h4000);
      drive(32'h4020, 0, 2'b00, 2'b00, 0, 0, 4'h0);
      step();
      chk("held_busy", busy_o, 1);
      chk("held_head_pc", pc, 32'h4000);
      busy_i = 0;
      step();
      busy_i = 1;
      chk("deq_busy_low", busy_o, 0);
      chk("deq_head_pc", pc, 32'h4008);
      step();
      hit = 0;
      chk("fifth_busy", busy_o, 1);
      busy_i = 0;
      for (int k = 0; k < 4; k++) begin
         chk("order_pc", pc, 32'h4008 + 32'(k) * 8);
         chk("order_ins0", ins0, 32'h4208 + 32'(k) * 8);
         step();
      end
      chk("order_empty", pkt_vld, 0);
      busy_i = 1;
      for (int i = 0; i < 3; i++) begin
         drive(32'h5000 + 32'(i) * 8, 0, 2'b00, 2'b00, 0, 0, 4'h0);
         step();
      end
      chk("pre_flush_pc", pc, 32'h5000);
      drive(32'h6000, 0, 2'b00, 2'b00, 0, 0, 4'h0);
      flush = 1;
      step();
      flush = 0; hit = 0;
      chk("flush_vld", pkt_vld, 0);
      chk("flush_busy", busy_o, 0);
      chk("flush_ins0", ins0, 0);
      drive(32'h7000, 0, 2'b00, 2'b00, 0, 0, 4'h0);
      step();
      hit = 0;
      chk("post_flush_pc", pc, 32'h7000);
      busy_i = 0;
      step();
      chk("post_flush_empty", pkt_vld, 0);
      drive(32'h8000, 0, 2'b00, 2'b00, 0, 0, 4'h0);
      rst = 1;
      step();
      rst = 0; hit = 0;
      chk("rst_prio_vld", pkt_vld, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
